// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types and helpers for the LED pattern generator
//
// Contents:
//   SPEED_W  width of the speed select input
//   mode_t   pattern select encoding (UP, DOWN, SCAN, GRAY)
//   gray_of  binary-to-Gray conversion, 32 bits wide; callers truncate
package led_pattern_pkg;

    localparam int SPEED_W = 3;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_SCAN = 2'd2,
        MODE_GRAY = 2'd3
    } mode_t;

    function automatic logic [31:0] gray_of(input logic [31:0] cnt);
        return cnt ^ (cnt >> 1);
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// rtl/led_tick_prescaler.sv - tick divider with pause, single-step and mode-change clear
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   speed        tick period select, period = 2^(BASE_SHIFT+speed) cycles
//   pause        1 = hold the divider; advances then come only from step edges
//   step         synchronous step request, rising edge advances while paused
//   mode_change  pattern mode is being reloaded this cycle; clears the divider
//   adv          one-cycle advance request (combinational, consumed on next edge)
module led_tick_prescaler
    import led_pattern_pkg::*;
#(
    parameter int PRESCALE_W = 28,
    parameter int BASE_SHIFT = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               step,
    input  logic               mode_change,
    output logic               adv
);

    localparam logic [PRESCALE_W-1:0] DIV_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] div_cnt;
    logic [PRESCALE_W-1:0] div_term;
    logic                  div_hit;
    logic                  step_q;
    logic                  step_edge;

    // Terminal value follows speed every cycle. If speed drops below the
    // current count, the equality never matches until div_cnt rolls over
    // through all-ones, which is the intended behaviour (no forced clear).
    always_comb begin
        div_term  = (DIV_ONE << (BASE_SHIFT + int'(speed))) - DIV_ONE;
        div_hit   = (div_cnt == div_term);
        step_edge = step & ~step_q;
        // A mode reload swallows any coincident advance.
        adv       = ~mode_change & (pause ? step_edge : div_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            if (mode_change) begin
                div_cnt <= '0;
            end else if (!pause) begin
                div_cnt <= div_hit ? '0 : div_cnt + DIV_ONE;
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - selectable LED pattern generator with pause/step and wrap pulse
//
// Optional feature macro: LED_PATTERN_PWM_EN (adds brightness input and PWM dimming)
//
// Ports:
//   CLOCK_50    system clock, rising edge
//   RESET_n     asynchronous active-low reset
//   mode        pattern select: 0 UP, 1 DOWN, 2 SCAN, 3 GRAY
//   speed       tick period = 2^(BASE_SHIFT+speed) cycles
//   pause       1 = hold pattern and divider
//   step        synchronous; rising edge advances one step while paused
//   brightness  (LED_PATTERN_PWM_EN only) 4-bit duty, on when pwm_cnt <= brightness
//   leds        registered pattern output
//   tick        one-cycle pulse with each leds update
//   wrap        one-cycle pulse with the leds value completing a pattern cycle
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LED_W      = 10,
    parameter int PRESCALE_W = 28,
    parameter int BASE_SHIFT = 18
) (
    input  logic               CLOCK_50,
    input  logic               RESET_n,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               step,
`ifdef LED_PATTERN_PWM_EN
    input  logic [3:0]         brightness,
`endif
    output logic [LED_W-1:0]   leds,
    output logic               tick,
    output logic               wrap
);

    localparam int               POS_W    = $clog2(LED_W);
    localparam logic [LED_W-1:0] CNT_ONE  = LED_W'(1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);

    mode_t             mode_in;
    mode_t             mode_q;
    mode_t             nxt_mode;
    logic              mode_change;
    logic              adv;

    logic [LED_W-1:0]  cnt;
    logic [POS_W-1:0]  pos;
    logic              dir_down;

    logic [LED_W-1:0]  nxt_cnt;
    logic [POS_W-1:0]  nxt_pos;
    logic              nxt_dir_down;
    logic              nxt_tick;
    logic              nxt_wrap;
    logic [LED_W-1:0]  nxt_pat;

    assign mode_in     = mode_t'(mode);
    assign mode_change = (mode_in != mode_q);

    led_tick_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .BASE_SHIFT (BASE_SHIFT)
    ) u_prescaler (
        .clk         (CLOCK_50),
        .rst_n       (RESET_n),
        .speed       (speed),
        .pause       (pause),
        .step        (step),
        .mode_change (mode_change),
        .adv         (adv)
    );

    // Next pattern state. A mode change reloads the state for the incoming
    // mode and always produces a tick without wrap.
    always_comb begin
        nxt_cnt      = cnt;
        nxt_pos      = pos;
        nxt_dir_down = dir_down;
        nxt_tick     = 1'b0;
        nxt_wrap     = 1'b0;
        nxt_mode     = mode_change ? mode_in : mode_q;

        if (mode_change) begin
            nxt_cnt      = (mode_in == MODE_DOWN) ? '1 : '0;
            nxt_pos      = '0;
            nxt_dir_down = 1'b0;
            nxt_tick     = 1'b1;
        end else if (adv) begin
            nxt_tick = 1'b1;
            case (mode_q)
                MODE_UP, MODE_GRAY: begin
                    nxt_cnt  = cnt + CNT_ONE;
                    nxt_wrap = (nxt_cnt == '0);
                end
                MODE_DOWN: begin
                    nxt_cnt  = cnt - CNT_ONE;
                    nxt_wrap = (nxt_cnt == '1);
                end
                MODE_SCAN: begin
                    nxt_pos = dir_down ? pos - POS_ONE : pos + POS_ONE;
                    // Reverse on arrival at an end so the end value is not repeated.
                    if (nxt_pos == POS_LAST) begin
                        nxt_dir_down = 1'b1;
                    end else if (nxt_pos == '0) begin
                        nxt_dir_down = 1'b0;
                    end
                    nxt_wrap = (nxt_pos == '0);
                end
                default: begin
                    nxt_cnt = cnt;
                end
            endcase
        end

        case (nxt_mode)
            MODE_GRAY: nxt_pat = LED_W'(gray_of(32'(nxt_cnt)));
            MODE_SCAN: nxt_pat = CNT_ONE << nxt_pos;
            default:   nxt_pat = nxt_cnt;
        endcase
    end

`ifdef LED_PATTERN_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_cnt <= brightness);

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            mode_q   <= MODE_UP;
            cnt      <= '0;
            pos      <= '0;
            dir_down <= 1'b0;
            leds     <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            mode_q   <= nxt_mode;
            cnt      <= nxt_cnt;
            pos      <= nxt_pos;
            dir_down <= nxt_dir_down;
            tick     <= nxt_tick;
            wrap     <= nxt_wrap;
`ifdef LED_PATTERN_PWM_EN
            leds     <= nxt_pat & {LED_W{pwm_on}};
`else
            leds     <= nxt_pat;
`endif
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the free-running LED counter on the DE1-SoC top level.
- Drives an LED row (LEDR or the display-board LEDs) with one of four selectable patterns, advancing at a switch-selectable rate.
- Adds pause and single-step control, wrap reporting, and optional PWM dimming.
- Instantiated from toplevel; inputs come from SW/KEY, output drives LEDR.

Parameters:
- LED_W, 10, number of LEDs driven; must be >= 2.
- PRESCALE_W, 28, width of the tick divider counter; must be >= BASE_SHIFT+8.
- BASE_SHIFT, 18, log2 of the tick period at speed 0 (2^18 cycles at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock; all state is on its rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- mode  in  2  pattern select: 0 UP, 1 DOWN, 2 SCAN, 3 GRAY.
- speed  in  3  tick period = 2^(BASE_SHIFT+speed) cycles.
- pause  in  1  1 = hold the pattern and the divider.
- step  in  1  already synchronous; each rising edge advances one step while paused.
- leds  out  LED_W  registered pattern output.
- tick  out  1  one-cycle pulse, coincident with each leds update.
- wrap  out  1  one-cycle pulse, coincident with the leds value that completes a pattern cycle.

Behaviour:
- Reset values: leds=0, tick=0, wrap=0, div_cnt=0, cnt=0, pos=0, dir=up, mode_q=UP, step_q=0. Reset is asynchronous, so it takes effect mid-cycle.
- Divider: div_cnt increments each cycle when pause=0. When div_cnt == 2^(BASE_SHIFT+speed)-1, adv=1 and div_cnt clears. speed is sampled every cycle.
- Speed change: if div_cnt already exceeds the new terminal value, div_cnt counts on to its all-ones value, wraps to 0, and continues. There is no forced clear.
- Step: step_edge = step & ~step_q. When pause=1, adv = step_edge. When pause=0, step is ignored. A held step gives exactly one advance.
- Mode change (mode != mode_q), highest priority:
  - Next edge: mode_q<=mode and div_cnt<=0.
  - Pattern reloads: UP cnt=0; DOWN cnt=all-ones; SCAN pos=0, dir=up; GRAY cnt=0.
  - tick=1 and wrap=0 on that update.
  - A coincident adv is dropped.
- Advance rules, applied on the edge ending the cycle in which adv=1:
  - UP: cnt+1, modulo 2^LED_W. wrap when the new cnt=0.
  - DOWN: cnt-1, modulo. wrap when the new cnt=all-ones.
  - SCAN: pos moves by dir. At pos=LED_W-1 dir flips to down; at pos=0 dir flips to up. Reversal happens on the same edge, with no repeated end value. wrap when the new pos=0. One cycle is 2*(LED_W-1) advances.
  - GRAY: cnt+1. wrap when the new cnt=0.
- leds (registered, same edge as the state update): UP/DOWN = cnt; GRAY = cnt ^ (cnt>>1); SCAN = one-hot at pos.
- tick/wrap are registered, so they are high in the same cycle the new leds value appears. Latency from adv to visible leds is 1 cycle.
- Pause: div_cnt and the pattern both hold. tick=0 except on a step.

Optional Feature:
- Macro: LED_PATTERN_PWM_EN.
- With the macro:
  - Extra input port brightness [3:0].
  - A free-running 4-bit pwm_cnt, reset to 0.
  - Each leds bit = pattern bit & (pwm_cnt <= brightness), registered.
  - 15 = always on; 0 = on 1 cycle in 16.
  - tick and wrap are unaffected.
- Without the macro: no brightness port; leds = pattern directly.

Decomposition:
- Package led_pattern_pkg:
  - typedef enum logic[1:0] mode_t {MODE_UP, MODE_DOWN, MODE_SCAN, MODE_GRAY}.
  - Function gray_of(cnt).
  - Localparam SPEED_W=3.
- Sub-module led_tick_prescaler:
  - Contains div_cnt, pause hold, step edge detect, and clear-on-mode-change.
  - Outputs the one-cycle adv signal.

Test Plan (LED_W=4, BASE_SHIFT=2, PRESCALE_W=12):
- Reset release, mode=0, speed=0, pause=0 -> leds steps 0,1,2,…,F,0, one new value every 4 cycles; tick every 4 cycles; wrap only with the 0 after F.
- speed=3 -> updates every 32 cycles. Switch to speed=0 when div_cnt=20 -> div_cnt runs to 4095, wraps, then 4-cycle ticks resume.
- mode=2 -> leds 0001,0010,0100,1000,0100,0010,0001; wrap with the final 0001 (every 6 ticks). mode=3 -> leds 0,1,3,2,6,7,5,4.
- pause=1 at leds=5 -> leds holds 5 for 100 cycles. step high for 10 cycles -> leds=6 exactly once, tick one pulse.
- mode 0->1 at leds=5 -> next cycle leds=F, tick=1, wrap=0, div_cnt=0; leds=E 4 cycles later.
- RESET_n low mid-cycle while leds=9 -> leds=0, tick=0, wrap=0 before the next edge. With LED_PATTERN_PWM_EN and brightness=3, UP at leds=F -> each bit high 4 of every 16 cycles.
